apb_master_bridge: RTL and testbench

//  CPU-side load/store to APB3 master bridge; sits between the RISC-V core data port and the APB slaves (GPO, GPI, UART, ...).

---
 rtl/apb_master_bridge.sv | 186 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB3 master bridge: address decode, IDLE/SETUP/ACCESS sequencing, read-back mux.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int unsigned NUM_SLV   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter logic [31:0] SLV_SPAN  = 32'h0000_1000,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  req,
   input  logic                  we,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  ready,
   output logic                  err,
   output logic [31:0]           PADDR,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic                  PENABLE,
   output logic [NUM_SLV-1:0]    PSEL,
   input  logic [32*NUM_SLV-1:0] PRDATA_in,
   input  logic [NUM_SLV-1:0]    PREADY_in
);

   localparam int unsigned IDXW  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int unsigned SHIFT = $clog2(SLV_SPAN);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_SLV-1:0]  psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [31:0]         paddr_q, paddr_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic [IDXW-1:0]     idx_q, idx_d;

   logic [31:0]         off;
   logic [31:0]         win;
   logic                hit;
   logic [IDXW-1:0]     dec_idx;
   logic                sel_ready;
   logic [31:0]         sel_rdata;
   logic                tmo;

   // Addresses below the base wrap to a huge offset and fall out of range.
   assign off     = addr - BASE_ADDR;
   assign win     = off >> SHIFT;
   assign hit     = (win < 32'(NUM_SLV));
   assign dec_idx = win[IDXW-1:0];

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IDXW'(i)) begin
            sel_ready = PREADY_in[i];
            sel_rdata = PRDATA_in[32*i +: 32];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

   logic [CNTW-1:0] cnt_q, cnt_d;

   // cnt_q counts ACCESS cycles already spent; the TIMEOUT-th one gives up.
   assign tmo = (cnt_q == CNTW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && req && hit)
         cnt_d = '0;
      else if (state_q == ACCESS)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      idx_d     = idx_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  state_d  = SETUP;
                  idx_d    = dec_idx;
                  psel_d   = NUM_SLV'(1) << dec_idx;
                  paddr_d  = off & (SLV_SPAN - 32'd1);
                  pwrite_d = we;
                  pwdata_d = wdata;
               end else begin
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d   = IDLE;
               psel_d    = '0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               if (!pwrite_q)
                  rdata_d = sel_rdata;
            end else if (tmo) begin
               state_d   = IDLE;
               psel_d    = '0;
               penable_d = 1'b0;
               ready_d   = 1'b1;
               err_d     = 1'b1;
               rdata_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
      end
   end

   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;
   assign rdata   = rdata_q;
   assign ready   = ready_q;
   assign err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge: a bench-side APB slave
// model checks the bus phase, a monitor checks every completion pulse.
module tb_apb_master_bridge;

   localparam int          NS   = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] SPAN = 32'h0000_1000;
   localparam int          TMO  = 16;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic              req = 1'b0;
   logic              we = 1'b0;
   logic [31:0]       addr = '0;
   logic [31:0]       wdata = '0;
   logic [31:0]       rdata;
   logic              ready;
   logic              err;
   logic [31:0]       PADDR;
   logic              PWRITE;
   logic [31:0]       PWDATA;
   logic              PENABLE;
   logic [NS-1:0]     PSEL;
   logic [32*NS-1:0]  PRDATA_in = '0;
   logic [NS-1:0]     PREADY_in = '0;

   apb_master_bridge #(
      .NUM_SLV(NS), .BASE_ADDR(BASE), .SLV_SPAN(SPAN), .TIMEOUT(TMO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
      .PSEL(PSEL), .PRDATA_in(PRDATA_in), .PREADY_in(PREADY_in)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          t0;
   } exp_t;

   typedef struct {
      int          idx;
      logic [31:0] paddr;
      logic        we;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
   } apb_t;

   exp_t exp_q[$];
   apb_t apb_q[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] model_rdata = '0;
   bit          abort = 0;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Completion monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (PSEL != '0)
            chk("psel_onehot", $countones(PSEL), 1);
         if (ready) begin
            chk("psel_idle_on_ready", {31'b0, PSEL != '0 || PENABLE}, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_ready", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("err", {31'b0, err}, {31'b0, e.err});
               chk("rdata", rdata, e.rdata);
               chk("latency", cyc - e.t0, e.lat);
            end
         end
      end
   end

   // APB slave model
   initial begin
      apb_t cur;
      int   acc;
      logic [32*NS-1:0] pr;
      logic [NS-1:0]    rdy;
      cur = '{idx: 0, paddr: 0, we: 0, wdata: 0, waits: 0, prdata: 0};
      acc = 0;
      forever begin
         @(negedge PCLK);
         for (int i = 0; i < NS; i++) pr[32*i +: 32] = $urandom;
         rdy = NS'($urandom);
         if (PSEL != '0 && !PENABLE) begin
            if (apb_q.size() == 0) begin
               chk("unexpected_setup", 1, 0);
            end else begin
               cur = apb_q.pop_front();
               chk("psel", 32'(PSEL), 32'(1) << cur.idx);
               chk("paddr", PADDR, cur.paddr);
               chk("pwrite", {31'b0, PWRITE}, {31'b0, cur.we});
               if (cur.we) chk("pwdata", PWDATA, cur.wdata);
            end
            acc = 0;
         end
         if (PSEL != '0) pr[32*cur.idx +: 32] = cur.prdata;
         if (PSEL != '0 && PENABLE) begin
            rdy[cur.idx] = (acc == cur.waits);
            acc++;
         end
         PRDATA_in = pr;
         PREADY_in = rdy;
      end
   end

   // Reference model: push expectations, drive request, hold until completion.
   task automatic issue(input logic [31:0] a, input logic w,
                        input logic [31:0] d, input int waits,
                        input logic [31:0] prd);
      exp_t        e;
      apb_t        t;
      logic [31:0] o;
      bit          done;
      o = a - BASE;
      e.t0 = cyc;
      if (o < NS * SPAN) begin
         t.idx = int'(o / SPAN);
         t.paddr = o % SPAN;
         t.we = w;
         t.wdata = d;
         t.waits = waits;
         t.prdata = prd;
         apb_q.push_back(t);
         e.err = 1'b0;
         e.lat = 3 + waits;
`ifdef APB_TIMEOUT_EN
         if (waits >= TMO) begin
            e.err = 1'b1;
            e.lat = 2 + TMO;
            model_rdata = '0;
         end else if (!w) model_rdata = prd;
`else
         if (!w) model_rdata = prd;
`endif
      end else begin
         e.err = 1'b1;
         e.lat = 1;
         model_rdata = '0;
      end
      e.rdata = model_rdata;
      exp_q.push_back(e);
      req = 1'b1; we = w; addr = a; wdata = d;
      done = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge PCLK);
         if (ready) begin
            done = 1;
            break;
         end
      end
      req = 1'b0;
      if (!done) begin
         chk("ready_timeout", 0, 1);
         abort = 1;
      end
   endtask

   task automatic rst_mid;
      apb_t t;
      bit   seen;
      t = '{idx: 2, paddr: 32'h10, we: 1'b0, wdata: 0, waits: 10,
            prdata: 32'hDEAD_BEEF};
      apb_q.push_back(t);
      req = 1'b1; we = 1'b0; addr = BASE + 2 * SPAN + 32'h10;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge PCLK);
         if (PENABLE) begin
            seen = 1;
            break;
         end
      end
      chk("reach_access", {31'b0, seen}, 1);
      req = 1'b0;
      #1 PRESET = 1'b1;
      #1;
      chk("rst_psel", 32'(PSEL), 0);
      chk("rst_penable", {31'b0, PENABLE}, 0);
      chk("rst_rdata", rdata, 0);
      #1 PRESET = 1'b0;
      model_rdata = '0;
      repeat (5) @(negedge PCLK);
   endtask

   initial begin
      logic [31:0] a;
      int          w;
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("reset_psel", 32'(PSEL), 0);
      chk("reset_penable", {31'b0, PENABLE}, 0);
      chk("reset_pwrite", {31'b0, PWRITE}, 0);
      chk("reset_paddr", PADDR, 0);
      chk("reset_pwdata", PWDATA, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_ready", {31'b0, ready}, 0);
      chk("reset_err", {31'b0, err}, 0);

      issue(32'h1000_0004, 1'b1, 32'h0000_000F, 0, 32'h0);
      @(negedge PCLK);
      issue(32'h1000_1000, 1'b0, 32'h0, 3, 32'hA5A5_0001);
      issue(32'h2000_0000, 1'b0, 32'h0, 0, 32'h0);
      @(negedge PCLK);
      rst_mid();
      issue(32'h1000_3008, 1'b0, 32'h0, 1, 32'h1234_5678);
      issue(32'h1000_0000, 1'b1, 32'h0000_000F, 1, 32'h0);
      issue(32'h1000_0004, 1'b1, 32'h0000_0005, 1, 32'h0);
      issue(BASE - 32'd4, 1'b0, 32'h0, 0, 32'h0);
      issue(BASE + NS * SPAN, 1'b1, 32'h1, 0, 32'h0);
      issue(32'h1000_2FFC, 1'b0, 32'h0, 20, 32'hCAFE_0002);

      for (int n = 0; n < 80 && !abort; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            do a = $urandom; while (a - BASE < NS * SPAN);
         end else begin
            a = BASE + $urandom_range(0, NS - 1) * SPAN
                + $urandom_range(0, 1023) * 4;
         end
         w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20)
                                          : $urandom_range(0, 3);
         issue(a, 1'($urandom), $urandom, w, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge PCLK);
      end

      repeat (5) @(negedge PCLK);
      chk("sb_drained", exp_q.size(), 0);
      chk("apb_drained", apb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
